// File: rtl/proj_minhash_sketch_if.sv
// proj_minhash_sketch_if
//   Stream bundle for the MinHash sketcher.
//   Input side : in_valid/in_ready handshake carrying one base (in_data) and
//                an end-of-fragment flag (in_last).
//   Output side: out_valid/out_ready handshake carrying one sketch entry
//                (out_sig, out_idx, out_chan) and an end-of-sketch flag (out_last).
//   master: the traffic source/sink around the sketcher; slave: the sketcher.
interface proj_minhash_sketch_if #(
  parameter int unsigned BASE_LEN = 2,
  parameter int unsigned SIG_LEN  = 32,
  parameter int unsigned IDX_LEN  = 10,
  parameter int unsigned CHAN_LEN = 2
);
  logic                in_valid;
  logic                in_ready;
  logic [BASE_LEN-1:0] in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [SIG_LEN-1:0]  out_sig;
  logic [IDX_LEN-1:0]  out_idx;
  logic [CHAN_LEN-1:0] out_chan;
  logic                out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sig, out_idx, out_chan, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sig, out_idx, out_chan, out_last
  );
endinterface

// File: rtl/proj_minhash_sketch.sv
// proj_minhash_sketch
//   Streaming multi-hash MinHash sketcher. Bases shift into a rolling k-mer
//   register; every complete k-mer is hashed by NUM_HASH seeded channels
//   (registered hash stage), and each channel keeps its minimum signature and
//   the start index of the k-mer that produced it. At fragment end (in_last or
//   FRAG_MAX bases) the NUM_HASH-entry sketch is drained in channel order.
// Ports
//   clk, rst_n : clock, synchronous active-low reset
//   sk (slave) : in_valid/in_ready/in_data/in_last base stream,
//                out_valid/out_ready/out_sig/out_idx/out_chan/out_last sketch stream
// Configuration
//   SKETCH_CANONICAL_EN : when defined, key = min(forward k-mer, reverse complement);
//                         otherwise the forward k-mer alone is hashed.
module proj_minhash_sketch #(
  parameter int unsigned BASE_LEN = 2,
  parameter int unsigned KMER_LEN = 16,
  parameter int unsigned SIG_LEN  = 32,
  parameter int unsigned NUM_HASH = 4,
  parameter int unsigned FRAG_MAX = 1024,
  parameter logic [31:0] SEED     = 32'h12345678,
  localparam int unsigned IDX_LEN  = $clog2(FRAG_MAX),
  localparam int unsigned CHAN_LEN = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1
) (
  input logic                 clk,
  input logic                 rst_n,
  proj_minhash_sketch_if.slave sk
);
  localparam int unsigned KW      = KMER_LEN * BASE_LEN;
  localparam int unsigned CNT_LEN = $clog2(FRAG_MAX + 1);
  localparam logic [SIG_LEN-1:0] MULT = SIG_LEN'(32'h2545F491);

  typedef enum logic [1:0] {ACC, FLUSH, DRAIN} state_t;

  state_t              state, state_next;
  logic [KW-1:0]       kmer, kmer_next;
  logic [CNT_LEN-1:0]  count, count_next;
  logic                accept, kvalid, frag_end, drain_hs, drain_done;
  logic [IDX_LEN-1:0]  kidx;
  logic [SIG_LEN-1:0]  key;
  logic [SIG_LEN-1:0]  hash    [NUM_HASH];
  logic                st_valid;
  logic [IDX_LEN-1:0]  st_idx;
  logic [SIG_LEN-1:0]  st_sig  [NUM_HASH];
  logic [SIG_LEN-1:0]  min_sig [NUM_HASH];
  logic [IDX_LEN-1:0]  min_idx [NUM_HASH];
  logic [CHAN_LEN-1:0] chan;

  assign accept     = sk.in_valid && (state == ACC);
  assign kmer_next  = {kmer[KW-BASE_LEN-1:0], sk.in_data};
  assign count_next = count + CNT_LEN'(1);
  assign kvalid     = count_next >= CNT_LEN'(KMER_LEN);
  assign kidx       = IDX_LEN'(count_next - CNT_LEN'(KMER_LEN));
  // Reaching FRAG_MAX bases ends the fragment even without in_last.
  assign frag_end   = sk.in_last || (count_next == CNT_LEN'(FRAG_MAX));
  assign drain_hs   = (state == DRAIN) && sk.out_ready;
  assign drain_done = drain_hs && (chan == CHAN_LEN'(NUM_HASH - 1));

`ifdef SKETCH_CANONICAL_EN
  // Reverse complement: complement of the newest base enters at the MSB end.
  logic [KW-1:0] rc, rc_next;
  assign rc_next = {~sk.in_data, rc[KW-1:BASE_LEN]};
  assign key     = (kmer_next < rc_next) ? SIG_LEN'(kmer_next) : SIG_LEN'(rc_next);
`else
  assign key = SIG_LEN'(kmer_next);
`endif

  always_comb begin
    for (int unsigned c = 0; c < NUM_HASH; c++) begin
      hash[c] = (key ^ SIG_LEN'(SEED + 32'(c) * 32'h9E3779B9)) * MULT;
    end
  end

  always_comb begin
    state_next   = state;
    sk.in_ready  = 1'b0;
    sk.out_valid = 1'b0;
    sk.out_last  = 1'b0;
    case (state)
      ACC: begin
        sk.in_ready = 1'b1;
        if (accept && frag_end) state_next = FLUSH;
      end
      // One cycle for the final k-mer's hash to reach the min compare.
      FLUSH: state_next = DRAIN;
      DRAIN: begin
        sk.out_valid = 1'b1;
        sk.out_last  = (chan == CHAN_LEN'(NUM_HASH - 1));
        if (drain_done) state_next = ACC;
      end
      default: state_next = ACC;
    endcase
  end

  assign sk.out_sig  = min_sig[chan];
  assign sk.out_idx  = min_idx[chan];
  assign sk.out_chan = chan;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ACC;
      kmer     <= '0;
      count    <= '0;
      st_valid <= 1'b0;
      st_idx   <= '0;
      chan     <= '0;
      for (int unsigned c = 0; c < NUM_HASH; c++) begin
        st_sig[c]  <= '0;
        min_sig[c] <= '1;
        min_idx[c] <= '1;
      end
`ifdef SKETCH_CANONICAL_EN
      rc <= '0;
`endif
    end else begin
      state    <= state_next;
      st_valid <= accept && kvalid;
      if (accept) begin
        kmer   <= kmer_next;
        count  <= count_next;
        st_idx <= kidx;
        for (int unsigned c = 0; c < NUM_HASH; c++) st_sig[c] <= hash[c];
`ifdef SKETCH_CANONICAL_EN
        rc <= rc_next;
`endif
      end
      // Strict compare: ties keep the earlier k-mer's index.
      for (int unsigned c = 0; c < NUM_HASH; c++) begin
        if (st_valid && (st_sig[c] < min_sig[c])) begin
          min_sig[c] <= st_sig[c];
          min_idx[c] <= st_idx;
        end
      end
      if (drain_hs) begin
        if (drain_done) begin
          chan  <= '0;
          kmer  <= '0;
          count <= '0;
          for (int unsigned c = 0; c < NUM_HASH; c++) begin
            min_sig[c] <= '1;
            min_idx[c] <= '1;
          end
`ifdef SKETCH_CANONICAL_EN
          rc <= '0;
`endif
        end else begin
          chan <= chan + CHAN_LEN'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_proj_minhash_sketch.sv
module tb_proj_minhash_sketch;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  proj_minhash_sketch_if #(.BASE_LEN(2), .SIG_LEN(32), .IDX_LEN(10), .CHAN_LEN(2)) sk ();

  proj_minhash_sketch #(
    .BASE_LEN(2), .KMER_LEN(16), .SIG_LEN(32), .NUM_HASH(4),
    .FRAG_MAX(1024), .SEED(32'h12345678)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sk(sk)
  );

  typedef struct {
    logic [31:0] sig;
    logic [9:0]  idx;
    logic [1:0]  chan;
    logic        last;
  } ent_t;

  ent_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Channel seeds: SEED + c*0x9E3779B9, summed by hand.
  logic [31:0] seeds [4] = '{32'h12345678, 32'hB06BD031, 32'h4EA349EA, 32'hECDAC3A3};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: scan every k-mer of the fragment, keep the strict minimum per channel.
  task automatic expect_frag(input logic [1:0] b[$]);
    logic [31:0] ms [4];
    logic [9:0]  mi [4];
    logic [31:0] fwd, rc, k, s;
    ent_t e;
    for (int c = 0; c < 4; c++) begin ms[c] = '1; mi[c] = '1; end
    for (int i = 0; i + 16 <= b.size(); i++) begin
      for (int j = 0; j < 16; j++) begin
        fwd[2*(15-j) +: 2] = b[i+j];
        rc[2*j +: 2]       = ~b[i+j];
      end
`ifdef SKETCH_CANONICAL_EN
      k = (fwd < rc) ? fwd : rc;
`else
      k = fwd;
`endif
      for (int c = 0; c < 4; c++) begin
        s = (k ^ seeds[c]) * 32'h2545F491;
        if (s < ms[c]) begin ms[c] = s; mi[c] = 10'(i); end
      end
    end
    for (int c = 0; c < 4; c++) begin
      e.sig = ms[c]; e.idx = mi[c]; e.chan = 2'(c); e.last = (c == 3);
      exp_q.push_back(e);
    end
  endtask

  // Drivers act at posedge+#1; the monitor samples at negedge.
  task automatic send(input logic [1:0] b[$], input bit with_last);
    int n;
    for (int i = 0; i < b.size(); i++) begin
      sk.in_valid = 1'b1;
      sk.in_data  = b[i];
      sk.in_last  = with_last && (i == b.size() - 1);
      n = 0;
      while (!sk.in_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (n == 100) check("in_ready_timeout", 1, 0);
      @(posedge clk); #1;
    end
    sk.in_valid = 1'b0;
    sk.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); #1; n++; end
    check("drain_timeout", 64'(exp_q.size()), 0);
  endtask

  task automatic wait_chan(input logic [1:0] ch);
    int n = 0;
    while (!(sk.out_valid && sk.out_chan == ch) && n < 100) begin @(posedge clk); #1; n++; end
    check("wait_chan_timeout", 64'(n == 100), 0);
  endtask

  task automatic monitor();
    bit   stalled = 0;
    ent_t held, e;
    forever begin
      @(negedge clk);
      if (rst_n && sk.out_valid) begin
        check("in_ready_in_drain", sk.in_ready, 0);
        if (stalled) begin
          check("stall_sig", sk.out_sig, held.sig);
          check("stall_idx", sk.out_idx, held.idx);
          check("stall_chan", sk.out_chan, held.chan);
          check("stall_last", sk.out_last, held.last);
        end
        if (sk.out_ready) begin
          stalled = 0;
          if (exp_q.size() == 0) check("unexpected_entry", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("out_sig", sk.out_sig, e.sig);
            check("out_idx", sk.out_idx, e.idx);
            check("out_chan", sk.out_chan, e.chan);
            check("out_last", sk.out_last, e.last);
          end
        end else begin
          stalled = 1;
          held.sig = sk.out_sig; held.idx = sk.out_idx;
          held.chan = sk.out_chan; held.last = sk.out_last;
        end
      end else begin
        if (stalled && rst_n) check("valid_dropped_in_stall", 0, 1);
        stalled = 0;
      end
    end
  endtask

  initial begin
    logic [1:0] q[$];
    logic [1:0] qa[$];
    ent_t e;
    rst_n = 1'b0;
    sk.in_valid = 1'b0; sk.in_data = '0; sk.in_last = 1'b0; sk.out_ready = 1'b1;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", sk.in_ready, 1);
    check("rst_out_valid", sk.out_valid, 0);
    check("rst_out_last", sk.out_last, 0);
    check("rst_out_chan", sk.out_chan, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Short fragment: no complete k-mer, entries stay all-ones.
    q.delete();
    for (int i = 0; i < 15; i++) q.push_back(2'($urandom_range(0, 3)));
    for (int c = 0; c < 4; c++) begin
      e.sig = 32'hFFFFFFFF; e.idx = 10'h3FF; e.chan = 2'(c); e.last = (c == 3);
      exp_q.push_back(e);
    end
    send(q, 1);
    wait_drain();

    // 20 x A: every k-mer hashes alike, index 0 must survive; check drain latency.
    qa.delete();
    for (int i = 0; i < 20; i++) qa.push_back(2'b00);
    expect_frag(qa);
    send(qa, 1);
    check("flush_out_valid", sk.out_valid, 0);
    check("flush_in_ready", sk.in_ready, 0);
    @(posedge clk); #1;
    check("drain_out_valid", sk.out_valid, 1);
    wait_drain();

    // Random 200 bases with a 5-cycle back-pressure stall on channel 1.
    q.delete();
    for (int i = 0; i < 200; i++) q.push_back(2'($urandom_range(0, 3)));
    expect_frag(q);
    send(q, 1);
    wait_chan(2'd1);
    sk.out_ready = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    sk.out_ready = 1'b1;
    wait_drain();

    // FRAG_MAX bases without in_last, then a fresh fragment indexed from 0.
    q.delete();
    for (int i = 0; i < 1024; i++) q.push_back(2'($urandom_range(0, 3)));
    expect_frag(q);
    send(q, 0);
    check("implicit_last_in_ready", sk.in_ready, 0);
    q.delete();
    for (int i = 0; i < 24; i++) q.push_back(2'($urandom_range(0, 3)));
    expect_frag(q);
    send(q, 1);
    wait_drain();

    // Reset while entry 2 is presented; remaining entries are discarded.
    q.delete();
    for (int i = 0; i < 30; i++) q.push_back(2'($urandom_range(0, 3)));
    expect_frag(q);
    send(q, 1);
    wait_chan(2'd2);
    rst_n = 1'b0;
    sk.out_ready = 1'b0;
    check("entries_left_at_reset", 64'(exp_q.size()), 2);
    exp_q.delete();
    @(posedge clk); #1;
    check("reset_out_valid", sk.out_valid, 0);
    check("reset_in_ready", sk.in_ready, 1);
    check("reset_out_chan", sk.out_chan, 0);
    rst_n = 1'b1;
    sk.out_ready = 1'b1;
    q.delete();
    for (int i = 0; i < 25; i++) q.push_back(2'($urandom_range(0, 3)));
    expect_frag(q);
    send(q, 1);
    wait_drain();

`ifdef SKETCH_CANONICAL_EN
    // 20 x T is the reverse complement of 20 x A: sketches must coincide.
    expect_frag(qa);
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(2'b11);
    send(q, 1);
    wait_drain();
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
